// File: rtl/uart_packet_rx.sv
// uart_packet_rx
//   Deframes packets [0xA5][LEN][LEN payload bytes][CSUM] popped from a
//   standard (registered-output) RX FIFO. The payload is streamed on a
//   valid/ready port before the frame is validated. After each frame or
//   error, a one-byte ACK (0x06) or NAK (0x15) is pushed into the TX FIFO.
//
//   Optional feature macro: UART_PKT_TIMEOUT_EN enables the inter-byte
//   timeout, which rejects a stalled frame with err_code 3.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   enable          1 = new RX FIFO reads allowed; 0 = hold
//   rx_empty        RX FIFO empty flag
//   rx_data         RX FIFO dout, valid the cycle after read_rx_data
//   read_rx_data    RX FIFO rd_en, single-cycle pulse
//   tx_full         TX FIFO full flag
//   tx_data         ACK/NAK byte; holds its last value between writes
//   write_tx_data   TX FIFO wr_en, single-cycle pulse
//   m_data/m_valid/m_ready/m_last  payload stream
//   frame_ok        1-cycle pulse: checksum good, ACK queued
//   frame_err       1-cycle pulse: frame rejected, NAK queued
//   err_code        with frame_err: 1 bad LEN, 2 bad CSUM, 3 timeout
module uart_packet_rx #(
   parameter int unsigned MAX_LEN        = 64,
   parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       rx_empty,
   input  logic [7:0] rx_data,
   output logic       read_rx_data,
   input  logic       tx_full,
   output logic [7:0] tx_data,
   output logic       write_tx_data,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam logic [7:0] ACK_BYTE    = 8'h06;
   localparam logic [7:0] NAK_BYTE    = 8'h15;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_PAY,
      S_PUSH,
      S_CSUM,
      S_REPLY
   } state_t;

   state_t     r_state;
   state_t     w_next;

   logic       r_rd_pend;
   logic [7:0] r_sum;
   logic [7:0] r_cnt;
   logic [7:0] r_m_data;
   logic       r_m_valid;
   logic       r_m_last;
   logic       r_ok;
   logic       r_err;
   logic [1:0] r_code;
   logic       r_nak;
   logic [7:0] r_tx_data;
   logic       r_wr;

   logic       w_byte_vld;
   logic       w_fetch;
   logic       w_rd;
   logic       w_go_reply;
   logic       w_reply_nak;
   logic [1:0] w_reply_code;
   logic       w_len_bad;
   logic [7:0] w_sum_next;
   logic       w_timeout;

   // A read issued last cycle means rx_data carries a fresh byte now.
   assign w_byte_vld = r_rd_pend;
   assign w_len_bad  = (rx_data == '0) || (32'(rx_data) > MAX_LEN);
   assign w_sum_next = r_sum + rx_data;

`ifdef UART_PKT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            w_to_run;

   // Frozen while waiting on m_ready (S_PUSH) or while enable is low.
   assign w_to_run  = enable && (r_state == S_LEN || r_state == S_PAY || r_state == S_CSUM);
   assign w_timeout = w_to_run && !w_byte_vld && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || r_state == S_HUNT || w_byte_vld) begin
         r_to_cnt <= '0;
      end else if (w_to_run) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end
`else
   // Keeps the parameter referenced when the timeout is compiled out.
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_fetch      = 1'b0;
      w_go_reply   = 1'b0;
      w_reply_nak  = 1'b0;
      w_reply_code = '0;
      case (r_state)
         S_HUNT: begin
            w_fetch = 1'b1;
            if (w_byte_vld && rx_data == SYNC_BYTE) w_next = S_LEN;
         end
         S_LEN: begin
            w_fetch = 1'b1;
            if (w_byte_vld) begin
               if (w_len_bad) begin
                  w_go_reply   = 1'b1;
                  w_reply_nak  = 1'b1;
                  w_reply_code = ERR_LEN;
               end else begin
                  w_next = S_PAY;
               end
            end
         end
         S_PAY: begin
            w_fetch = 1'b1;
            if (w_byte_vld) w_next = S_PUSH;
         end
         S_PUSH: begin
            if (m_ready) w_next = (r_cnt == 8'd1) ? S_CSUM : S_PAY;
         end
         S_CSUM: begin
            w_fetch = 1'b1;
            if (w_byte_vld) begin
               w_go_reply = 1'b1;
               if (w_sum_next != '0) begin
                  w_reply_nak  = 1'b1;
                  w_reply_code = ERR_CSUM;
               end
            end
         end
         S_REPLY: begin
            if (!tx_full) w_next = S_HUNT;
         end
         default: w_next = S_HUNT;
      endcase
      if (w_timeout) begin
         w_fetch      = 1'b0;
         w_go_reply   = 1'b1;
         w_reply_nak  = 1'b1;
         w_reply_code = ERR_TIMEOUT;
      end
      if (w_go_reply) w_next = S_REPLY;
      w_rd = w_fetch && enable && !rx_empty && !r_rd_pend && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_pend <= 1'b0;
         r_sum     <= '0;
         r_cnt     <= '0;
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_code    <= '0;
         r_nak     <= 1'b0;
         r_tx_data <= '0;
         r_wr      <= 1'b0;
      end else begin
         r_rd_pend <= w_rd;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_code    <= '0;
         r_wr      <= 1'b0;
         case (r_state)
            S_HUNT: r_sum <= '0;
            S_LEN: begin
               if (w_byte_vld) begin
                  r_sum <= rx_data;
                  r_cnt <= rx_data;
               end
            end
            S_PAY: begin
               if (w_byte_vld) begin
                  r_m_data  <= rx_data;
                  r_m_valid <= 1'b1;
                  r_m_last  <= (r_cnt == 8'd1);
                  r_sum     <= w_sum_next;
               end
            end
            S_PUSH: begin
               if (m_ready) begin
                  r_m_valid <= 1'b0;
                  r_m_last  <= 1'b0;
                  r_cnt     <= r_cnt - 8'd1;
               end
            end
            S_REPLY: begin
               // The write is registered, so tx_data and write_tx_data
               // change together and tx_data holds between replies.
               if (!tx_full) begin
                  r_wr      <= 1'b1;
                  r_tx_data <= r_nak ? NAK_BYTE : ACK_BYTE;
               end
            end
            default: ;
         endcase
         if (w_go_reply) begin
            r_ok      <= !w_reply_nak;
            r_err     <= w_reply_nak;
            r_code    <= w_reply_code;
            r_nak     <= w_reply_nak;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
         end
      end
   end

   assign read_rx_data  = w_rd;
   assign tx_data       = r_tx_data;
   assign write_tx_data = r_wr;
   assign m_data        = r_m_data;
   assign m_valid       = r_m_valid;
   assign m_last        = r_m_last;
   assign frame_ok      = r_ok;
   assign frame_err     = r_err;
   assign err_code      = r_code;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Self-checking bench for uart_packet_rx: table of directed frames, hand
// sequences for backpressure / TX-full / enable / reset / timeout, and
// randomized streams checked against a byte-stream parser model.
module tb_uart_packet_rx;

   localparam int MAXL   = 64;
   localparam int TO_CYC = 200;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      logic [63:0] in_b;
      int          n_in;
      logic [31:0] pay;
      int          n_pay;
      int          res;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       rx_empty;
   logic [7:0] rx_data = '0;
   logic       read_rx_data;
   logic       tx_full = 1'b0;
   logic [7:0] tx_data;
   logic       write_tx_data;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b1;
   logic       m_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   int checks = 0;
   int failures = 0;

   logic [7:0] rx_mem [0:4095];
   int         rd_ptr = 0;
   int         wr_ptr = 0;
   int         cyc = 0;

   logic [7:0] got_pay[$];
   bit         got_last[$];
   int         got_res[$];
   logic [7:0] got_tx[$];
   logic [7:0] exp_pay[$];
   bit         exp_last[$];
   int         exp_res[$];
   logic [7:0] exp_tx[$];
   int         exp_tx_n = 0;

   int         prot_err = 0;
   int         stab_err = 0;
   int         rd_count = 0;
   int         last_pay_cyc = 0;
   int         res_cyc = 0;
   logic       p_valid = 1'b0;
   logic       p_ready = 1'b0;
   logic       p_last = 1'b0;
   logic [7:0] p_data = '0;

   vec_t vt[9];

   uart_packet_rx #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .reset(reset), .enable(enable), .rx_empty(rx_empty),
      .rx_data(rx_data), .read_rx_data(read_rx_data), .tx_full(tx_full),
      .tx_data(tx_data), .write_tx_data(write_tx_data), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // RX FIFO model: registered output, data valid the cycle after rd_en.
   assign rx_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (read_rx_data && rd_ptr != wr_ptr) begin
         rx_data <= rx_mem[rd_ptr % 4096];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (m_valid && m_ready) begin
            got_pay.push_back(m_data);
            got_last.push_back(m_last);
            last_pay_cyc = cyc;
         end
         if (frame_ok) begin
            got_res.push_back(0);
            res_cyc = cyc;
         end
         if (frame_err) begin
            got_res.push_back(int'(err_code));
            res_cyc = cyc;
         end
         if (write_tx_data) got_tx.push_back(tx_data);
         if (read_rx_data) rd_count++;
         if (read_rx_data && (m_valid || rx_empty)) prot_err++;
         if (frame_ok && frame_err) prot_err++;
         if (p_valid && !p_ready && !(m_valid && m_data == p_data && m_last == p_last)) stab_err++;
      end
      p_valid = m_valid && !reset;
      p_ready = m_ready;
      p_last  = m_last;
      p_data  = m_data;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic bound_fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_mem[wr_ptr % 4096] = b;
      wr_ptr++;
   endtask

   task automatic clear_all();
      got_pay.delete(); got_last.delete(); got_res.delete(); got_tx.delete();
      exp_pay.delete(); exp_last.delete(); exp_res.delete(); exp_tx.delete();
   endtask

   task automatic wait_done(input int budget, input bit rnd, input string nm);
      int n;
      n = 0;
      while (!(rd_ptr == wr_ptr && got_tx.size() >= exp_tx_n)) begin
         tick(1);
         if (rnd) begin
            m_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 4) != 0);
            tx_full = ($urandom_range(0, 3) == 0);
         end
         n++;
         if (n > budget) begin
            bound_fail({nm, " completion"});
            break;
         end
      end
      m_ready = 1'b1;
      enable  = 1'b1;
      tx_full = 1'b0;
      tick(6);
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      while (!m_valid && n < 100) begin
         tick(1);
         n++;
      end
      if (!m_valid) bound_fail({nm, " m_valid"});
   endtask

   task automatic compare_logs(input string nm);
      chk({nm, " payload count"}, got_pay.size(), exp_pay.size());
      for (int k = 0; k < got_pay.size() && k < exp_pay.size(); k++) begin
         chk({nm, " m_data"}, 32'(got_pay[k]), 32'(exp_pay[k]));
         chk({nm, " m_last"}, 32'(got_last[k]), 32'(exp_last[k]));
      end
      chk({nm, " result count"}, got_res.size(), exp_res.size());
      for (int k = 0; k < got_res.size() && k < exp_res.size(); k++)
         chk({nm, " result/err_code"}, got_res[k], exp_res[k]);
      chk({nm, " tx count"}, got_tx.size(), exp_tx.size());
      for (int k = 0; k < got_tx.size() && k < exp_tx.size(); k++)
         chk({nm, " tx_data"}, 32'(got_tx[k]), 32'(exp_tx[k]));
   endtask

   // Reference: scan the byte stream for frames using the framing rules.
   function automatic void model_stream(input bq_t s);
      int i, n, len, sum;
      i = 0;
      n = s.size();
      while (i < n) begin
         if (s[i] != 8'hA5) begin
            i++;
            continue;
         end
         if (i + 1 >= n) break;
         len = int'(s[i+1]);
         if (len == 0 || len > MAXL) begin
            exp_res.push_back(1);
            exp_tx.push_back(8'h15);
            i += 2;
            continue;
         end
         if (i + 2 + len >= n) break;
         sum = len;
         for (int k = 0; k < len; k++) begin
            exp_pay.push_back(s[i+2+k]);
            exp_last.push_back(k == len - 1);
            sum += int'(s[i+2+k]);
         end
         sum += int'(s[i+2+len]);
         if (sum % 256 == 0) begin
            exp_res.push_back(0);
            exp_tx.push_back(8'h06);
         end else begin
            exp_res.push_back(2);
            exp_tx.push_back(8'h15);
         end
         i += len + 3;
      end
   endfunction

   function automatic bq_t gen_stream(input int nframes);
      bq_t        s;
      logic [7:0] b, sum;
      int         len, kind;
      for (int f = 0; f < nframes; f++) begin
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            s.push_back(b);
         end
         kind = $urandom_range(0, 9);
         s.push_back(8'hA5);
         if (kind == 0) begin
            s.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
            continue;
         end
         len = (f == 3) ? MAXL : $urandom_range(1, 12);
         s.push_back(8'(len));
         sum = 8'(len);
         for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            s.push_back(b);
            sum = sum + b;
         end
         b = 8'h00 - sum;
         if (kind == 1) b = b ^ 8'($urandom_range(1, 255));
         s.push_back(b);
      end
      return s;
   endfunction

   task automatic load_vec_exp(input int i);
      logic [31:0] p;
      p = vt[i].pay;
      for (int k = 0; k < vt[i].n_pay; k++) begin
         exp_pay.push_back(p[31-8*k -: 8]);
         exp_last.push_back(k == vt[i].n_pay - 1);
      end
      exp_res.push_back(vt[i].res);
      exp_tx.push_back(vt[i].res == 0 ? 8'h06 : 8'h15);
   endtask

   task automatic push_vec(input int i);
      logic [63:0] v;
      v = vt[i].in_b;
      for (int k = 0; k < vt[i].n_in; k++) push_byte(v[63-8*k -: 8]);
   endtask

   task automatic apply_vec(input int i, input string nm);
      clear_all();
      load_vec_exp(i);
      push_vec(i);
      exp_tx_n = 1;
      wait_done(2000, 1'b0, nm);
      compare_logs(nm);
   endtask

   task automatic run_model_stream(input bq_t s, input bit rnd, input string nm);
      clear_all();
      model_stream(s);
      foreach (s[k]) push_byte(s[k]);
      exp_tx_n = exp_tx.size();
      wait_done(40 * s.size() + 500, rnd, nm);
      compare_logs(nm);
   endtask

   initial begin
      bq_t s;
      int  r0;
      logic [7:0] sum, b;

      vt[0] = '{in_b: 64'hA503112233970000, n_in: 6, pay: 32'h11223300, n_pay: 3, res: 0};
      vt[1] = '{in_b: 64'hA503112233A70000, n_in: 6, pay: 32'h11223300, n_pay: 3, res: 2};
      vt[2] = '{in_b: 64'hA502102000000000, n_in: 5, pay: 32'h10200000, n_pay: 2, res: 2};
      vt[3] = '{in_b: 64'h00FFA50000000000, n_in: 4, pay: 32'h0,        n_pay: 0, res: 1};
      vt[4] = '{in_b: 64'hA5017F8000000000, n_in: 4, pay: 32'h7F000000, n_pay: 1, res: 0};
      vt[5] = '{in_b: 64'hA541000000000000, n_in: 2, pay: 32'h0,        n_pay: 0, res: 1};
      vt[6] = '{in_b: 64'h12A501A55A000000, n_in: 5, pay: 32'hA5000000, n_pay: 1, res: 0};
      vt[7] = '{in_b: 64'hA502A5A5B4000000, n_in: 5, pay: 32'hA5A50000, n_pay: 2, res: 0};
      vt[8] = '{in_b: 64'hA5FF000000000000, n_in: 2, pay: 32'h0,        n_pay: 0, res: 1};

      // Reset: outputs low, no read even with a byte waiting.
      reset = 1'b1;
      push_byte(8'h3C);
      tick(3);
      chk("reset outputs", 32'({read_rx_data, write_tx_data, m_valid, m_last, frame_ok,
                                frame_err, err_code, tx_data, m_data}), 32'h0);
      reset = 1'b0;
      tick(6);

      for (int i = 0; i < 9; i++) apply_vec(i, $sformatf("vec%0d", i));

      // Largest legal LEN followed by the smallest illegal one.
      s.delete();
      s.push_back(8'hA5); s.push_back(8'(MAXL));
      sum = 8'(MAXL);
      for (int k = 0; k < MAXL; k++) begin
         b = 8'($urandom_range(0, 255));
         s.push_back(b);
         sum = sum + b;
      end
      s.push_back(8'h00 - sum);
      s.push_back(8'hA5); s.push_back(8'(MAXL + 1));
      run_model_stream(s, 1'b0, "maxlen");

      // Backpressure: each byte held 50 cycles with m_ready low.
      clear_all();
      load_vec_exp(0);
      m_ready = 1'b0;
      push_vec(0);
      for (int k = 0; k < 3; k++) begin
         wait_valid("bp");
         r0 = rd_count;
         tick(50);
         chk("bp no read while held", rd_count, r0);
         chk("bp no early transfer", got_pay.size(), k);
         m_ready = 1'b1;
         tick(1);
         m_ready = 1'b0;
      end
      m_ready = 1'b1;
      exp_tx_n = 1;
      wait_done(500, 1'b0, "bp");
      compare_logs("bp");

      // TX FIFO full: reply delayed, never dropped or duplicated.
      clear_all();
      load_vec_exp(4);
      tx_full = 1'b1;
      push_vec(4);
      r0 = 0;
      while (got_res.size() == 0 && r0 < 200) begin
         tick(1);
         r0++;
      end
      if (got_res.size() == 0) bound_fail("txfull result");
      tick(20);
      chk("txfull write held", got_tx.size(), 0);
      tx_full = 1'b0;
      exp_tx_n = 1;
      wait_done(200, 1'b0, "txfull");
      compare_logs("txfull");

      // enable=0 blocks reads.
      clear_all();
      load_vec_exp(2);
      enable = 1'b0;
      r0 = rd_count;
      push_vec(2);
      tick(10);
      chk("enable low no read", rd_count, r0);
      enable = 1'b1;
      exp_tx_n = 1;
      wait_done(500, 1'b0, "enable");
      compare_logs("enable");

      // Reset mid-frame: frame discarded, no NAK.
      clear_all();
      m_ready = 1'b0;
      push_byte(8'hA5); push_byte(8'h03); push_byte(8'h11);
      wait_valid("midreset");
      reset = 1'b1;
      tick(1);
      chk("midreset outputs", 32'({read_rx_data, write_tx_data, m_valid, m_last, frame_ok,
                                   frame_err, err_code, m_data}), 32'h0);
      wr_ptr = rd_ptr;
      tick(1);
      reset = 1'b0;
      m_ready = 1'b1;
      tick(TO_CYC + 60);
      chk("midreset no result", got_res.size(), 0);
      chk("midreset no reply", got_tx.size(), 0);
      apply_vec(4, "after reset");

`ifdef UART_PKT_TIMEOUT_EN
      // Stalled frame rejected with err_code 3.
      clear_all();
      exp_pay.push_back(8'h11); exp_last.push_back(1'b0);
      exp_res.push_back(3); exp_tx.push_back(8'h15);
      push_byte(8'hA5); push_byte(8'h03); push_byte(8'h11);
      r0 = 0;
      while (got_res.size() == 0 && r0 < 600) begin
         tick(1);
         r0++;
      end
      if (got_res.size() == 0) bound_fail("timeout result");
      chk("timeout delay window", 32'((res_cyc - last_pay_cyc) >= TO_CYC - 5 &&
                                      (res_cyc - last_pay_cyc) <= TO_CYC + 10), 32'd1);
      exp_tx_n = 1;
      wait_done(200, 1'b0, "timeout");
      compare_logs("timeout");
      chk("timeout m_valid low", 32'(m_valid), 32'd0);
`endif

      for (int r = 0; r < 3; r++) begin
         s = gen_stream(20);
         run_model_stream(s, 1'b1, $sformatf("random%0d", r));
      end

      chk("protocol violations", prot_err, 0);
      chk("m_valid/m_data stability", stab_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
